nn_conv_deltabp_array: RTL

Multi-channel, parametrised back-propagation delta generator for stochastic convolutional layers. For each of C feature-map channels it forms the signed stochastic sum of N next-layer delta·weight products with a saturating W-bit difference counter, then gates the result with the burst-gate derivative zp. It also accumulates a signed per-channel delta estimate over a programmable stream epoch. It sits between the next layer's delta outputs and this layer's weight-update logic.

---
 rtl/nn_conv_deltabp_array.sv | 138 +++++++++++++
 1 files changed

// File: rtl/nn_conv_deltabp_array.sv
// Per-channel stochastic delta back-propagation: saturating difference counter gated by zp, plus epoch estimate.
// Latency: 1 cycle from sampled inputs to delta_out/SIGN_out; est/epoch_done update on the last enabled cycle of an epoch.
// Backpressure: none; EN=0 freezes all state and forces delta_out/epoch_done low.
//
// Ports:
//   CLK, INIT           clock (rising edge), synchronous active-low reset
//   EN                  global stream enable
//   delta, SIGN_delta   C*N delta bitstreams and signs (channel c at [c*N +: N])
//   alpha, SIGN_alpha   C*N weight bitstreams and signs
//   zp, R_condition     per-channel derivative gate and channel enable
//   delta_out, SIGN_out per-channel gated delta bitstream and its sign
//   est, epoch_done     per-channel signed epoch estimate (c at [c*EW +: EW]), valid strobe
module nn_conv_deltabp_array #(
  parameter int N              = 3,
  parameter int C              = 2,
  parameter int DW             = 3,
  parameter int LEN            = 8,
  // Sized so that +LEN (every emitted bit positive) is representable as well as -LEN.
  parameter int EW             = $clog2(LEN + 1) + 1,
  parameter int CLEAR_ON_EPOCH = 0
) (
  input  logic              CLK,
  input  logic              INIT,
  input  logic              EN,
  input  logic [C*N-1:0]    delta,
  input  logic [C*N-1:0]    SIGN_delta,
  input  logic [C*N-1:0]    alpha,
  input  logic [C*N-1:0]    SIGN_alpha,
  input  logic [C-1:0]      zp,
  input  logic [C-1:0]      R_condition,
  output logic [C-1:0]      delta_out,
  output logic [C-1:0]      SIGN_out,
  output logic [C*EW-1:0]   est,
  output logic              epoch_done
);

  localparam int CW  = $clog2(N + 1);
  // D + P - Q can never overflow this width.
  localparam int TW  = DW + CW + 1;
  localparam int ECW = $clog2(LEN);

  localparam logic [ECW-1:0]       ELAST  = ECW'(LEN - 1);
  localparam logic signed [TW-1:0] DMAX   = TW'((2 ** (DW - 1)) - 1);
  localparam logic signed [TW-1:0] DMIN   = TW'(-(2 ** (DW - 1)));
  localparam logic signed [TW-1:0] T_ONE  = TW'(1);
  localparam logic signed [EW-1:0] E_PONE = EW'(1);
  localparam logic signed [EW-1:0] E_MONE = '1;

  function automatic logic signed [DW-1:0] sat(input logic signed [TW-1:0] v);
    if (v > DMAX)      return DMAX[DW-1:0];
    else if (v < DMIN) return DMIN[DW-1:0];
    else               return v[DW-1:0];
  endfunction

  logic signed [DW-1:0] d_q     [C];
  logic signed [EW-1:0] acc_q   [C];
  logic [ECW-1:0]       ecnt;

  logic signed [DW-1:0] d_nxt   [C];
  logic signed [EW-1:0] acc_sum [C];
  logic [C-1:0]         emit;
  logic [C-1:0]         sgn_nxt;
  logic                 last;

  always_comb begin
    logic [N-1:0]         p;
    logic [N-1:0]         s;
    logic [CW-1:0]        pcnt;
    logic [CW-1:0]        qcnt;
    logic signed [TW-1:0] t;
    logic                 raw;
    last    = EN && (ecnt == ELAST);
    emit    = '0;
    sgn_nxt = SIGN_out;
    for (int c = 0; c < C; c++) begin
      p    = delta[c*N +: N] & alpha[c*N +: N];
      s    = SIGN_delta[c*N +: N] ^ SIGN_alpha[c*N +: N];
      pcnt = '0;
      qcnt = '0;
      for (int i = 0; i < N; i++) begin
        pcnt = pcnt + CW'(p[i] & ~s[i]);
        qcnt = qcnt + CW'(p[i] & s[i]);
      end
      t        = TW'(d_q[c]) + TW'(pcnt) - TW'(qcnt);
      raw      = 1'b0;
      d_nxt[c] = d_q[c];
      if (EN && R_condition[c]) begin
        if (t > 0) begin
          raw        = 1'b1;
          sgn_nxt[c] = 1'b0;
          d_nxt[c]   = sat(t - T_ONE);
        end else if (t < 0) begin
          raw        = 1'b1;
          sgn_nxt[c] = 1'b1;
          d_nxt[c]   = sat(t + T_ONE);
        end else begin
          d_nxt[c]   = '0;
        end
      end
      if (last && (CLEAR_ON_EPOCH != 0)) d_nxt[c] = '0;
      // The estimate counts emitted (zp-gated) bits, not raw ones.
      emit[c]    = raw & zp[c];
      acc_sum[c] = acc_q[c] + (emit[c] ? (sgn_nxt[c] ? E_MONE : E_PONE) : '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (!INIT) begin
      ecnt       <= '0;
      delta_out  <= '0;
      SIGN_out   <= '0;
      est        <= '0;
      epoch_done <= 1'b0;
      for (int c = 0; c < C; c++) begin
        d_q[c]   <= '0;
        acc_q[c] <= '0;
      end
    end else if (EN) begin
      ecnt       <= last ? '0 : ecnt + ECW'(1);
      delta_out  <= emit;
      SIGN_out   <= sgn_nxt;
      epoch_done <= last;
      for (int c = 0; c < C; c++) begin
        d_q[c] <= d_nxt[c];
        if (last) begin
          est[c*EW +: EW] <= acc_sum[c];
          acc_q[c]        <= '0;
        end else begin
          acc_q[c]        <= acc_sum[c];
        end
      end
    end else begin
      delta_out  <= '0;
      epoch_done <= 1'b0;
    end
  end

endmodule
